// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults, the variable-latency encoding and the per-register entry
// state type for the issue hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int LAT_W_DEF   = 3;
    localparam int FWD_EN_DEF  = 1;
    localparam int CNT_W_DEF   = 16;

    // An issue latency of zero marks a result retired through the wb port.
    localparam int LAT_VAR     = 0;

    typedef enum logic [1:0] {
        ENT_IDLE = 2'd0,
        ENT_FIX  = 2'd1,
        ENT_VAR  = 2'd2
    } entry_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue, writeback and flush signals between the issue stage and the
// scoreboard; the issue stage is the master.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int LAT_W  = LAT_W_DEF
);
    logic              iss_valid;
    logic              iss_ready;
    logic [REG_AW-1:0] iss_src1;
    logic [REG_AW-1:0] iss_src2;
    logic              iss_src1_en;
    logic              iss_src2_en;
    logic [REG_AW-1:0] iss_dst;
    logic              iss_wen;
    logic [LAT_W-1:0]  iss_lat;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic              flush;
    logic              stall;

    modport master (
        output iss_valid, iss_src1, iss_src2, iss_src1_en, iss_src2_en,
               iss_dst, iss_wen, iss_lat, wb_valid, wb_dst, flush,
        input  iss_ready, stall
    );

    modport slave (
        input  iss_valid, iss_src1, iss_src2, iss_src1_en, iss_src2_en,
               iss_dst, iss_wen, iss_lat, wb_valid, wb_dst, flush,
        output iss_ready, stall
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: tracks the pending write of a single register.
//   state    | meaning
//   ENT_IDLE | no write pending
//   ENT_FIX  | fixed-latency write pending, cnt counts down to retirement
//   ENT_VAR  | variable-latency write pending until a matching wb
module hsb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             flush,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             wb_hit,
    output logic             busy,
    output logic             is_var,
    output logic [LAT_W-1:0] cnt
);
    entry_state_e     state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            state_q <= ENT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ENT_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ENT_IDLE: begin
                    if (set) begin
                        cnt_d   = set_lat;
                        state_d = (set_lat == LAT_W'(LAT_VAR)) ? ENT_VAR : ENT_FIX;
                    end
                end
                ENT_FIX: begin
                    cnt_d = cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        state_d = ENT_IDLE;
                    end
                end
                ENT_VAR: begin
                    if (wb_hit) begin
                        state_d = ENT_IDLE;
                    end
                end
                default: begin
                    state_d = ENT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy   = (state_q != ENT_IDLE);
    assign is_var = (state_q == ENT_VAR);
    assign cnt    = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: gates instruction issue on RAW/WAW hazards
// against pending fixed- and variable-latency writes.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int LAT_W   = LAT_W_DEF,
    parameter int FWD_EN  = FWD_EN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               core_clk,
    input  logic               core_rst,
    hazard_scoreboard_if.slave bus,
    output logic [REG_NUM-1:0] busy_vec,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               wb_err
);
    logic [REG_NUM-1:0]            var_vec;
    logic [REG_NUM-1:0][LAT_W-1:0] cnt_vec;
    logic                          wb_valid;
    logic [REG_AW-1:0]             wb_dst;
    logic                          src1_ok, src2_ok, dst_ok;
    logic                          fire, wb_live, wb_bad;

    assign wb_valid = bus.wb_valid;
    assign wb_dst   = bus.wb_dst;

    // A source is usable if its producer writes back this very cycle.
    function automatic logic src_ok(input logic en, input logic [REG_AW-1:0] idx);
        logic fwd_fix, fwd_var;
        fwd_fix = (FWD_EN != 0) && !var_vec[idx] && (cnt_vec[idx] == LAT_W'(1));
        fwd_var = (FWD_EN != 0) && var_vec[idx] && wb_valid && (wb_dst == idx);
        return !en || (idx == '0) || !busy_vec[idx] || fwd_fix || fwd_var;
    endfunction

    always_comb begin
        src1_ok = src_ok(bus.iss_src1_en, bus.iss_src1);
        src2_ok = src_ok(bus.iss_src2_en, bus.iss_src2);
        dst_ok  = !bus.iss_wen || (bus.iss_dst == '0) || !busy_vec[bus.iss_dst];
    end

    assign bus.iss_ready = !bus.flush && src1_ok && src2_ok && dst_ok;
    assign bus.stall     = bus.iss_valid && !bus.iss_ready;
    assign fire          = bus.iss_valid && bus.iss_ready;
    assign wb_live       = wb_valid && !bus.flush;
    assign wb_bad        = wb_live && !(busy_vec[wb_dst] && var_vec[wb_dst]);

    assign busy_vec[0] = 1'b0;
    assign var_vec[0]  = 1'b0;
    assign cnt_vec[0]  = '0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
        hsb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .core_clk (core_clk),
            .core_rst (core_rst),
            .flush    (bus.flush),
            .set      (fire && bus.iss_wen && (bus.iss_dst == REG_AW'(r))),
            .set_lat  (bus.iss_lat),
            .wb_hit   (wb_live && (wb_dst == REG_AW'(r))),
            .busy     (busy_vec[r]),
            .is_var   (var_vec[r]),
            .cnt      (cnt_vec[r])
        );
    end

    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            wb_err <= 1'b0;
        end else if (wb_bad) begin
            wb_err <= 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            stall_cnt <= '0;
        end else if (bus.stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, strict, 2-bit
// stall counter) share one stimulus stream and are checked against a model.
module tb_hazard_scoreboard;

    localparam int NI = 3;

    logic core_clk = 1'b0;
    logic core_rst = 1'b0;
    always #5 core_clk = ~core_clk;

    logic       iss_valid, s1_en, s2_en, wen, wb_valid, flush;
    logic [4:0] s1, s2, dst, wb_dst;
    logic [2:0] lat;

    logic [NI-1:0]       rdy, stl, werr;
    logic [NI-1:0][31:0] bv;
    logic [NI-1:0][15:0] sc;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int CW = (k == 2) ? 2 : 16;
        logic [CW-1:0] sc_w;
        hazard_scoreboard_if #(.REG_AW(5), .LAT_W(3)) bus ();
        assign bus.iss_valid   = iss_valid;
        assign bus.iss_src1    = s1;
        assign bus.iss_src2    = s2;
        assign bus.iss_src1_en = s1_en;
        assign bus.iss_src2_en = s2_en;
        assign bus.iss_dst     = dst;
        assign bus.iss_wen     = wen;
        assign bus.iss_lat     = lat;
        assign bus.wb_valid    = wb_valid;
        assign bus.wb_dst      = wb_dst;
        assign bus.flush       = flush;
        assign rdy[k]          = bus.iss_ready;
        assign stl[k]          = bus.stall;
        assign sc[k]           = 16'(sc_w);
        hazard_scoreboard #(
            .REG_NUM (32),
            .REG_AW  (5),
            .LAT_W   (3),
            .FWD_EN  ((k == 1) ? 0 : 1),
            .CNT_W   (CW)
        ) dut (
            .core_clk  (core_clk),
            .core_rst  (core_rst),
            .bus       (bus),
            .busy_vec  (bv[k]),
            .stall_cnt (sc_w),
            .wb_err    (werr[k])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: per register a count of remaining busy cycles, or a flag for an
    // open-ended write waiting on writeback.
    int m_rem [NI][32];
    bit m_var [NI][32];
    int m_sc  [NI];
    bit m_err [NI];

    function automatic bit m_busy(int k, int r);
        return m_var[k][r] || (m_rem[k][r] > 0);
    endfunction

    function automatic bit m_src_ok(int k, bit en, int s);
        if (!en || s == 0 || !m_busy(k, s)) return 1'b1;
        if (k == 1) return 1'b0;
        if (!m_var[k][s] && m_rem[k][s] == 1) return 1'b1;
        if (m_var[k][s] && wb_valid && int'(wb_dst) == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(int k);
        bit d_ok;
        d_ok = !wen || dst == 5'd0 || !m_busy(k, int'(dst));
        return !flush && d_ok && m_src_ok(k, s1_en, int'(s1)) && m_src_ok(k, s2_en, int'(s2));
    endfunction

    function automatic logic [31:0] m_bv(int k);
        logic [31:0] v;
        v = '0;
        for (int r = 1; r < 32; r++) v[r] = m_busy(k, r);
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge core_clk or negedge core_rst);
            if (!core_rst) begin
                for (int k = 0; k < NI; k++) begin
                    for (int r = 0; r < 32; r++) begin
                        m_rem[k][r] = 0;
                        m_var[k][r] = 1'b0;
                    end
                    m_sc[k]  = 0;
                    m_err[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < NI; k++) begin
                    bit r_ok;
                    int sat;
                    r_ok = m_ready(k);
                    sat  = (k == 2) ? 3 : 65535;
                    if (iss_valid && !r_ok && m_sc[k] < sat) m_sc[k]++;
                    if (flush) begin
                        for (int r = 0; r < 32; r++) begin
                            m_rem[k][r] = 0;
                            m_var[k][r] = 1'b0;
                        end
                    end else begin
                        for (int r = 0; r < 32; r++)
                            if (!m_var[k][r] && m_rem[k][r] > 0) m_rem[k][r]--;
                        if (wb_valid) begin
                            if (m_var[k][wb_dst]) m_var[k][wb_dst] = 1'b0;
                            else m_err[k] = 1'b1;
                        end
                        if (iss_valid && r_ok && wen && dst != 5'd0) begin
                            if (lat == 3'd0) m_var[k][dst] = 1'b1;
                            else m_rem[k][dst] = int'(lat);
                        end
                    end
                end
            end
        end
    end

    always @(negedge core_clk) begin
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_ready(k)));
            check($sformatf("stall%0d", k), 32'(stl[k]), 32'(iss_valid && !m_ready(k)));
            check($sformatf("busy_vec%0d", k), bv[k], m_bv(k));
            check($sformatf("stall_cnt%0d", k), 32'(sc[k]), 32'(m_sc[k]));
            check($sformatf("wb_err%0d", k), 32'(werr[k]), 32'(m_err[k]));
        end
    end

    task automatic clr();
        iss_valid = 0; s1_en = 0; s2_en = 0; wen = 0; wb_valid = 0; flush = 0;
        s1 = '0; s2 = '0; dst = '0; wb_dst = '0; lat = '0;
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic put_wr(input int d, input int l);
        clr();
        iss_valid = 1; wen = 1; dst = 5'(d); lat = 3'(l);
    endtask

    initial begin
        clr();
        @(negedge core_clk);
        check("rst_busy", bv[0], 32'h0);
        check("rst_cnt", 32'(sc[2]), 32'h0);
        check("rst_ready", 32'(rdy), 32'h7);
        flush = 1;
        #1 check("rst_ready_flush", 32'(rdy), 32'h0);
        step();
        core_rst = 1; clr();
        step();

        // fixed latency 3 on r5, then a reader of r5 every cycle
        put_wr(5, 3);
        @(negedge core_clk) check("fire5", 32'(rdy), 32'h7);
        step();
        for (int i = 1; i <= 4; i++) begin
            clr(); iss_valid = 1; s1_en = 1; s1 = 5'd5;
            @(negedge core_clk);
            check("raw_fwd_ready", 32'(rdy[0]), 32'(i >= 3));
            check("raw_strict_ready", 32'(rdy[1]), 32'(i >= 4));
            check("busy5", 32'(bv[0][5]), 32'(i <= 3));
            step();
        end
        clr();
        @(negedge core_clk);
        check("stall_cnt_strict", 32'(sc[1]), 32'd3);
        check("stall_cnt_fwd", 32'(sc[0]), 32'd2);
        step();

        // variable latency on r7 released by writeback
        put_wr(7, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            clr(); iss_valid = 1; s2_en = 1; s2 = 5'd7;
            @(negedge core_clk) check("var_stall", 32'(rdy), 32'h0);
            step();
        end
        clr(); iss_valid = 1; s2_en = 1; s2 = 5'd7; wb_valid = 1; wb_dst = 5'd7;
        @(negedge core_clk) check("wb_bypass", 32'(rdy), 32'h5);
        step();
        clr(); iss_valid = 1; s2_en = 1; s2 = 5'd7;
        @(negedge core_clk);
        check("busy7_clear", 32'({bv[2][7], bv[1][7], bv[0][7]}), 32'h0);
        check("cnt_after_var0", 32'(sc[0]), 32'd5);
        check("cnt_after_var1", 32'(sc[1]), 32'd7);
        check("cnt_saturated", 32'(sc[2]), 32'd3);
        step();

        // WAW on r9, then writes to r0 never stall nor mark busy
        put_wr(9, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            put_wr(9, 1);
            @(negedge core_clk) check("waw_stall", 32'(rdy), 32'h0);
            step();
        end
        clr(); wb_valid = 1; wb_dst = 5'd9;
        step();
        for (int i = 0; i < 3; i++) begin
            put_wr(0, 2);
            @(negedge core_clk);
            check("r0_ready", 32'(rdy), 32'h7);
            check("r0_busy", bv[0], 32'h0);
            step();
        end

        // flush with r3 fixed and r4 variable pending
        put_wr(3, 7);
        step();
        put_wr(4, 0);
        @(negedge core_clk) check("busy_r3", bv[0], 32'h8);
        step();
        clr(); flush = 1;
        @(negedge core_clk);
        check("busy_r3r4", bv[0], 32'h18);
        check("flush_ready", 32'(rdy), 32'h0);
        step();
        clr();
        @(negedge core_clk);
        check("flush_busy", bv[1], 32'h0);
        check("no_err_yet", 32'(werr), 32'h0);
        step();
        wb_valid = 1; wb_dst = 5'd4;
        step();
        clr();
        @(negedge core_clk) check("wb_err_set", 32'(werr), 32'h7);
        step();

        // async reset in the middle of a countdown
        put_wr(6, 7);
        step();
        clr(); iss_valid = 1; s1_en = 1; s1 = 5'd6;
        @(negedge core_clk) check("pre_rst_stall", 32'(rdy), 32'h0);
        #2 core_rst = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("arst_busy", bv[k], 32'h0);
            check("arst_cnt", 32'(sc[k]), 32'h0);
            check("arst_err", 32'(werr[k]), 32'h0);
        end
        step();
        core_rst = 1;
        clr(); iss_valid = 1; flush = 1;
        step();
        clr();
        @(negedge core_clk);
        check("cnt_restart2", 32'(sc[2]), 32'd1);
        check("cnt_restart0", 32'(sc[0]), 32'd1);
        step();

        // randomized traffic over a small register window
        for (int c = 0; c < 3000; c++) begin
            if (c == 1503) core_rst = 1;
            clr();
            iss_valid = ($urandom_range(0, 99) < 70);
            s1_en     = ($urandom_range(0, 99) < 60);
            s2_en     = ($urandom_range(0, 99) < 40);
            s1        = 5'($urandom_range(0, 7));
            s2        = 5'($urandom_range(0, 7));
            wen       = ($urandom_range(0, 99) < 75);
            dst       = 5'($urandom_range(0, 7));
            lat       = ($urandom_range(0, 99) < 30) ? 3'd0 : 3'($urandom_range(1, 7));
            flush     = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 30) begin
                int cand [$];
                wb_valid = 1;
                for (int r = 1; r < 8; r++) if (m_var[0][r]) cand.push_back(r);
                if (cand.size() > 0 && $urandom_range(0, 99) < 85)
                    wb_dst = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                else
                    wb_dst = 5'($urandom_range(0, 7));
            end
            if (c == 1500) #2 core_rst = 0;
            step();
        end

        clr();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
